// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the RV32I instruction-fetch sequencer.
// Optional misaligned-redirect trapping is selected with PC_CTRL_MISALIGN_TRAP_EN.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_VALID = 2'b10,
        ST_FAULT = 2'b11
    } pc_state_e;

    localparam logic [1:0]  FAULT_NONE     = 2'b00;
    localparam logic [1:0]  FAULT_TIMEOUT  = 2'b01;
    localparam logic [1:0]  FAULT_MISALIGN = 2'b10;

    localparam logic [31:0] PC_INCR = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_ctrl_rv32i_if.sv
// Instruction-memory bus plus decode handshake between the fetch sequencer
// (master) and the memory/decode side (slave).
interface pc_ctrl_rv32i_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  stall
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output stall
    );

endinterface

// File: rtl/pc_rv32i.sv
// RV32I program-counter register; loads pc_in every cycle and boots at 0.
module pc_rv32i (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out
);

    // PC storage, cleared asynchronously to the boot address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out <= 32'h0000_0000;
        end else begin
            pc_out <= pc_in;
        end
    end

endmodule

// File: rtl/pc_ctrl_rv32i.sv
// Instruction-fetch sequencer: PC ownership, one-at-a-time imem fetch, decode
// handshake, redirects and sticky timeout fault. Option: PC_CTRL_MISALIGN_TRAP_EN.
module pc_ctrl_rv32i
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    pc_ctrl_rv32i_if.master       fetch,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    output logic [31:0]           fault_pc,
    output logic                  busy
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    pc_state_e   state_r;
    logic [7:0]  cnt_r;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;
    logic [1:0]  cause_r;
    logic [31:0] fault_pc_r;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [31:0] redir_target_s;
    logic        redir_trap_s;

    pc_rv32i u_pc (
        .clk    (clk),
        .reset  (reset),
        .pc_in  (pc_next_s),
        .pc_out (pc_s)
    );

    // Redirect target legalisation: trap on misalignment or silently word-align
    always_comb begin
`ifdef PC_CTRL_MISALIGN_TRAP_EN
        redir_target_s = redirect_pc;
        redir_trap_s   = is_misaligned(redirect_pc);
`else
        redir_target_s = align_word(redirect_pc);
        redir_trap_s   = 1'b0;
`endif
    end

    // Next-PC mux: redirect beats accept; a trapping redirect leaves the PC alone
    always_comb begin
        pc_next_s = pc_s;
        if (redirect) begin
            if (redir_trap_s) begin
                pc_next_s = pc_s;
            end else begin
                pc_next_s = redir_target_s;
            end
        end else if ((state_r == ST_VALID) && !fetch.stall) begin
            pc_next_s = pc_s + PC_INCR;
        end else begin
            pc_next_s = pc_s;
        end
    end

    // Fetch FSM with timeout counter, captured instruction and fault record
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            instr_r    <= 32'h0000_0000;
            instr_pc_r <= 32'h0000_0000;
            cause_r    <= FAULT_NONE;
            fault_pc_r <= 32'h0000_0000;
        end else if (redirect && redir_trap_s) begin
            state_r    <= ST_FAULT;
            cnt_r      <= 8'd0;
            cause_r    <= FAULT_MISALIGN;
            fault_pc_r <= redirect_pc;
        end else if (redirect) begin
            cnt_r <= 8'd0;
            case (state_r)
                ST_IDLE:  state_r <= start ? ST_REQ : ST_IDLE;
                ST_REQ:   state_r <= ST_REQ;
                ST_VALID: state_r <= ST_REQ;
                ST_FAULT: begin
                    state_r    <= ST_REQ;
                    cause_r    <= FAULT_NONE;
                    fault_pc_r <= 32'h0000_0000;
                end
                default:  state_r <= ST_IDLE;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_REQ;
                        cnt_r   <= 8'd0;
                    end
                end
                ST_REQ: begin
                    if (fetch.imem_ready) begin
                        instr_r    <= fetch.imem_rdata;
                        instr_pc_r <= pc_s;
                        state_r    <= ST_VALID;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r    <= ST_FAULT;
                        cause_r    <= FAULT_TIMEOUT;
                        fault_pc_r <= pc_s;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_VALID: begin
                    if (!fetch.stall) begin
                        state_r <= ST_REQ;
                        cnt_r   <= 8'd0;
                    end
                end
                ST_FAULT: state_r <= ST_FAULT;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

    assign fetch.imem_req    = (state_r == ST_REQ);
    assign fetch.imem_addr   = pc_s;
    assign fetch.instr_valid = (state_r == ST_VALID);
    assign fetch.instr       = instr_r;
    assign fetch.instr_pc    = instr_pc_r;
    assign fault             = (state_r == ST_FAULT);
    assign fault_cause       = cause_r;
    assign fault_pc          = fault_pc_r;
    assign busy              = (state_r != ST_IDLE);

endmodule

// File: tb/tb_pc_ctrl_rv32i.sv
// Self-checking bench for pc_ctrl_rv32i: directed scenarios, then random
// stimulus compared every cycle against a behavioural fetch model.
module tb_pc_ctrl_rv32i;

    localparam int unsigned TO = 4;
    localparam int M_IDLE  = 0;
    localparam int M_REQ   = 1;
    localparam int M_VALID = 2;
    localparam int M_FAULT = 3;

    logic        clk;
    logic        reset;
    logic        start;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic        busy;

    pc_ctrl_rv32i_if bus ();

    pc_ctrl_rv32i #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch       (bus),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fault_pc    (fault_pc),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          m_mode;
    int          m_wait;
    int          m_cause;
    logic [31:0] m_pc, m_instr, m_ipc, m_fpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("imem_req",    32'(bus.imem_req),    32'(m_mode == M_REQ));
        chk("imem_addr",   bus.imem_addr,        m_pc);
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_mode == M_VALID));
        chk("instr",       bus.instr,            m_instr);
        chk("instr_pc",    bus.instr_pc,         m_ipc);
        chk("fault",       32'(fault),           32'(m_mode == M_FAULT));
        chk("fault_cause", 32'(fault_cause),     32'(m_cause));
        chk("fault_pc",    fault_pc,             m_fpc);
        chk("busy",        32'(busy),            32'(m_mode != M_IDLE));
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_wait = 0; m_cause = 0;
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_fpc = 32'h0;
    endtask

    // One clock of fetch behaviour, from the inputs currently applied
    task automatic model_step();
        logic [31:0] tgt;
        if (redirect) begin
`ifdef PC_CTRL_MISALIGN_TRAP_EN
            if (redirect_pc % 4 != 0) begin
                m_mode = M_FAULT; m_cause = 2; m_fpc = redirect_pc; m_wait = 0;
                return;
            end
            tgt = redirect_pc;
`else
            tgt = redirect_pc - (redirect_pc % 4);
`endif
            m_pc = tgt; m_wait = 0;
            if (m_mode == M_FAULT) begin
                m_cause = 0; m_fpc = 32'h0; m_mode = M_REQ;
            end else if (m_mode == M_VALID) begin
                m_mode = M_REQ;
            end else if (m_mode == M_IDLE && start) begin
                m_mode = M_REQ;
            end
            return;
        end
        case (m_mode)
            M_IDLE: if (start) begin m_mode = M_REQ; m_wait = 0; end
            M_REQ: begin
                if (bus.imem_ready) begin
                    m_instr = bus.imem_rdata; m_ipc = m_pc; m_mode = M_VALID;
                end else begin
                    m_wait = m_wait + 1;
                    if (m_wait == TO) begin
                        m_mode = M_FAULT; m_cause = 1; m_fpc = m_pc;
                    end
                end
            end
            M_VALID: if (!bus.stall) begin m_pc = m_pc + 32'd4; m_mode = M_REQ; m_wait = 0; end
            default: ;
        endcase
    endtask

    task automatic drive(input logic st, input logic stl, input logic rd,
                         input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata);
        start = st; bus.stall = stl; redirect = rd; redirect_pc = rpc;
        bus.imem_ready = rdy; bus.imem_rdata = rdata;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] rpc;
        int          quiet;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b1;

        // zero-wait fetch stream from PC 0
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013); tick();
        start = 1'b0; tick();
        chk("first_instr_pc", bus.instr_pc, 32'h0);
        chk("first_instr", bus.instr, 32'h0000_0013);
        tick();
        chk("addr_4", bus.imem_addr, 32'h4);
        tick(); tick();
        chk("addr_8", bus.imem_addr, 32'h8);

        // stall holds the presented instruction
        tick();
        bus.stall = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_ipc", bus.instr_pc, 32'h8);
            chk("stall_noreq", 32'(bus.imem_req), 32'h0);
        end
        bus.stall = 1'b0; tick();
        chk("after_stall_addr", bus.imem_addr, 32'hC);

        // redirect beats a same-cycle returned word
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF); tick();
        chk("redir_addr", bus.imem_addr, 32'h100);
        chk("redir_novalid", 32'(bus.instr_valid), 32'h0);

        // timeout fault at PC 8
        drive(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0); tick();
        redirect = 1'b0;
        repeat (3) tick();
        chk("no_fault_yet", 32'(fault), 32'h0);
        tick();
        chk("timeout_fault", 32'(fault), 32'h1);
        chk("timeout_cause", 32'(fault_cause), 32'h1);
        chk("timeout_pc", fault_pc, 32'h8);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0); tick();
        chk("fault_sticky", 32'(fault), 32'h1);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0); tick();
        chk("fault_cleared", 32'(fault), 32'h0);
        chk("fault_exit_req", 32'(bus.imem_req), 32'h1);

        // PC wrap after the last word
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0); tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678); tick();
        chk("wrap_ipc", bus.instr_pc, 32'hFFFF_FFFC);
        bus.imem_ready = 1'b0; tick();
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // misaligned redirect target
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0); tick();
`ifdef PC_CTRL_MISALIGN_TRAP_EN
        chk("misalign_fault", 32'(fault_cause), 32'h2);
        chk("misalign_pc", fault_pc, 32'h102);
`else
        chk("align_addr", bus.imem_addr, 32'h100);
`endif
        drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0); tick();
        redirect = 1'b0;

        // asynchronous reset mid-transfer, later ready ignored
        #2 reset = 1'b0;
        #1 model_reset(); check_all();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D); tick();
        chk("reset_idle", 32'(busy), 32'h0);

        // randomized traffic
        quiet = 0;
        for (int i = 0; i < 800; i++) begin
            if (i % 80 == 40) quiet = 6;
            case ($urandom_range(0, 7))
                0:       rpc = 32'hFFFF_FFFC;
                1:       rpc = $urandom();
                default: rpc = $urandom() & 32'h0000_FFFC;
            endcase
            drive(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), rpc,
                  (quiet > 0) ? 1'b0 : 1'($urandom_range(0, 1)), $urandom());
            if (quiet > 0) quiet--;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_ctrl_rv32i.md
# pc_ctrl_rv32i

Instruction-fetch sequencer for the RV32I core. It owns the 32-bit program counter register, issues one instruction-memory request at a time over a req/ready handshake, and presents fetched words to decode with a valid/stall handshake. It also applies control-flow redirects from execute and raises a sticky fault on fetch timeout.

## Interface
- TIMEOUT_CYCLES, 16: cycles in REQ without imem_ready before a timeout fault; legal range 2..255.
- clk  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-low reset. Low: all state cleared immediately.
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching at the current PC. Ignored outside IDLE.
- stall  in  1  decode cannot accept; holds the presented instruction.
- redirect  in  1  control-flow change; PC loaded from redirect_pc.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  fetch request; high exactly while in REQ.
- imem_addr  out  32  fetch address, equal to PC.
- imem_ready  in  1  memory completes the transfer this cycle; imem_rdata valid.
- imem_rdata  in  32  fetched word.
- instr_valid  out  1  instr/instr_pc valid; high exactly while in VALID.
- instr  out  32  captured instruction word.
- instr_pc  out  32  address of instr.
- fault  out  1  sticky fetch fault; high exactly while in FAULT.
- fault_cause  out  2  2'b01 timeout, 2'b10 misaligned target, 2'b00 none.
- fault_pc  out  32  offending address.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQ, VALID, FAULT.
- IDLE: start -> REQ. redirect -> PC <= redirect_pc; stays IDLE.
- REQ: imem_req=1, imem_addr=PC. On imem_ready: instr <= imem_rdata, instr_pc <= PC, -> VALID. Transfer completes only on a cycle with req and ready both high.
- VALID: instr_valid=1. If stall=0: PC <= PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0), -> REQ. If stall=1: hold instr, instr_pc, and PC.
- Timeout counter: cleared on entering REQ and on every redirect. Increments each REQ cycle without ready. Terminal value TIMEOUT_CYCLES-1 with no ready that cycle -> FAULT, fault_cause=01, fault_pc=PC.
- Redirect precedence: redirect beats imem_ready, accept, and timeout in the same cycle.
  - In REQ: any same-cycle returned word is discarded. PC <= redirect_pc; stay REQ; counter cleared.
  - In VALID: the held instruction is dropped. PC <= redirect_pc; -> REQ.
  - In FAULT: clears fault_cause and fault_pc to 0. PC <= redirect_pc; -> REQ.
- FAULT: the only exits are redirect or reset. start is ignored.
- Reset values: state IDLE, PC 0, counter 0. All outputs 0.

## Timing
- start sampled high at edge N -> imem_req high in cycle N+1.
- imem_ready high in cycle M -> instr_valid high from cycle M+1.
- Accept (instr_valid=1, stall=0) in cycle K -> imem_req with imem_addr=PC+4 in cycle K+1.
- Peak throughput: one instruction per 2 cycles with zero-wait memory.
- imem_req, instr_valid, fault, and busy are decoded from the state register only, with no combinational path from inputs.
- imem_addr tracks the PC register directly.
- Reset asserted mid-transfer: outputs 0 asynchronously. Any later imem_ready is ignored because the block is in IDLE.

## Configuration
- PC_CTRL_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]!=0 goes to FAULT from any state instead of REQ/IDLE.
  - fault_cause=10, fault_pc=redirect_pc; PC is unchanged.
  - In FAULT, a misaligned redirect reloads fault_pc and stays in FAULT.
- PC_CTRL_MISALIGN_TRAP_EN undefined:
  - redirect_pc[1:0] is forced to 0 when loaded into the PC.
  - fault_cause 10 is never produced.

## Structure
- Shared package pc_ctrl_pkg:
  - State enum.
  - Fault-cause constants FAULT_NONE, FAULT_TIMEOUT, FAULT_MISALIGN.
  - Constant PC_INCR = 4.
- Sub-module: instantiate the team's pc_rv32i as the PC register.
  - The FSM drives its PCin with the next-PC mux, selecting among hold, PC+4, and redirect_pc.
  - pc_rv32i's reset value 0 defines the boot PC.

## Test plan
- Reset, start, memory returns 32'h00000013 with zero wait, stall=0: instr_valid with instr_pc 0, then imem_addr 4, then 8.
- stall=1 for 3 cycles in VALID: instr and instr_pc stable, no imem_req; release -> next imem_addr = prior+4.
- Redirect to 32'h0000_0100 in the same cycle as imem_ready: word discarded; next fetch at 0x100; instr_valid stays low.
- TIMEOUT_CYCLES=4, imem_ready held low from PC 8: fault high after 4 REQ cycles, fault_cause=01, fault_pc=8; redirect to 0 -> REQ, fault low.
- PC 32'hFFFF_FFFC accepted -> next imem_addr 0.
- Redirect to 32'h0000_0102:
  - With PC_CTRL_MISALIGN_TRAP_EN: FAULT, cause 10, fault_pc 0x102.
  - Without it: fetch at 0x100.
